reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-read-port register file; successor to the fixed 16-entry, 2-read CPU register file.
//  Adds width/depth/port-count parameters, an optional hardwired-zero register 0, a sequenced clear
//  engine with Busy/ClearDone handshake, and optional write-to-read bypass. Sits in the CPU decode stage.
// PARAMETERS
//  DATA_W    18  register width in bits
//  ADDR_W    4   select width; DEPTH = 2**ADDR_W entries
//  NUM_READ  2   number of independent read ports (>=1)
//  ZERO_REG  0   1: entry 0 always reads 0 and ignores writes
// PORTS
//  Clock        in   1                  single clock, all state updates on posedge
//  Clear_n      in   1                  synchronous active-low reset
//  ReadSelect   in   NUM_READ*ADDR_W    port p address = ReadSelect[p*ADDR_W +: ADDR_W]
//  ReadData     out  NUM_READ*DATA_W    port p data    = ReadData[p*DATA_W +: DATA_W] (combinational)
//  WriteSelect  in   ADDR_W             write address
//  WriteData    in   DATA_W             write data
//  WriteEnable  in   1                  write request
//  WriteReady   out  1                  write accepted this cycle iff WriteEnable && WriteReady
//  ClearReq     in   1                  request sequenced clear of all entries
//  Busy         out  1                  clear sweep in progress
//  ClearDone    out  1                  one-cycle pulse after sweep completes
// BEHAVIOUR
//  - Reset (Clear_n=0 at posedge): all entries 0, FSM=IDLE, sweep ptr 0; Busy=0, ClearDone=0, WriteReady=1.
//    Reset mid-sweep aborts sweep; no ClearDone pulse is produced.
//  - Reads: zero-latency combinational; each port independent; ports may select same address.
//    ZERO_REG=1 and select 0 -> 0. While Busy=1 all ports read 0.
//  - Writes: accepted write updates entry at next posedge; new value visible to reads the cycle after.
//    ZERO_REG=1 and WriteSelect=0 -> accepted but discarded. WriteEnable with WriteReady=0 -> dropped, no effect.
//  - FSM states IDLE, SWEEP, DONE:
//    IDLE : ClearReq=1 -> SWEEP, ptr<=0. WriteReady=1.
//    SWEEP: each cycle entry[ptr]<=0, ptr<=ptr+1; at ptr==DEPTH-1 -> DONE. Busy=1, WriteReady=0.
//           Sweep takes exactly DEPTH cycles. ClearReq ignored.
//    DONE : ClearDone=1 for one cycle -> IDLE. Busy=0, WriteReady=1; ClearReq ignored in DONE.
//  - Simultaneous accepted write and ClearReq in IDLE: write performed, then swept (ends 0).
//  - ptr is ADDR_W bits; wrap from DEPTH-1 never used (FSM leaves SWEEP first).
//  - No arithmetic on data; all widths exact, no truncation/extension.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: accepted write forwarded combinationally to any read port whose select
//    equals WriteSelect in the same cycle (ZERO_REG and Busy rules take priority).
//  Not defined: same-cycle read returns the pre-write value; write visible next cycle only.
// STRUCTURE
//  Package reg_file_pkg: FSM state enum (IDLE/SWEEP/DONE), default DATA_W/ADDR_W constants.
//  Sub-module reg_file_read_port: one instance per read port (address decode, zero/Busy gating, bypass mux),
//    generated NUM_READ times. Storage array and FSM live in reg_file_mp.
// TESTING
//  1 Reset: write 18'h3FFFF to all entries, pulse Clear_n low 1 cycle -> every port reads 0, WriteReady=1.
//  2 Write entry 5 = 18'h1234, read on ports 0 and 1 next cycle -> both 18'h1234; entry 6 unchanged.
//  3 ZERO_REG=1: write entry 0 = 18'h00FF -> reads 0; ZERO_REG=0 same write -> reads 18'h00FF.
//  4 Fill entries, ClearReq 1 cycle -> Busy high exactly 16 cycles, reads 0, write during sweep dropped,
//    ClearDone pulses once, then all entries read 0.
//  5 Same cycle write entry 3 = 18'h2AAAA, read entry 3: with REGFILE_BYPASS_EN -> 18'h2AAAA that cycle;
//    without -> old value, 18'h2AAAA next cycle.
//  6 Clear_n low at sweep cycle 7 -> FSM IDLE, Busy=0, no ClearDone, all entries 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared FSM state type and default geometry for the multi-port register file
package reg_file_pkg;
  localparam int DefDataW = 18;
  localparam int DefAddrW = 4;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} regState_t;
endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read/write/clear bus of the register file; master drives selects and requests
interface reg_file_mp_if import reg_file_pkg::*; #(
  parameter int DATA_W = DefDataW,
  parameter int ADDR_W = DefAddrW,
  parameter int NUM_READ = 2
);
  logic [NUM_READ*ADDR_W-1:0] ReadSelect;
  logic [NUM_READ*DATA_W-1:0] ReadData;
  logic [ADDR_W-1:0] WriteSelect;
  logic [DATA_W-1:0] WriteData;
  logic WriteEnable;
  logic WriteReady;
  logic ClearReq;
  logic Busy;
  logic ClearDone;
  modport master(output ReadSelect, WriteSelect, WriteData, WriteEnable, ClearReq,
                 input ReadData, WriteReady, Busy, ClearDone);
  modport slave(input ReadSelect, WriteSelect, WriteData, WriteEnable, ClearReq,
                output ReadData, WriteReady, Busy, ClearDone);
endinterface

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one combinational read port with zero-register and Busy gating
// REGFILE_BYPASS_EN adds same-cycle forwarding of an accepted write.
module reg_file_read_port #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 4,
  parameter int ZERO_REG = 0
) (
  input  logic [ADDR_W-1:0] Select,
  input  logic [DATA_W-1:0] Regs [2**ADDR_W],
  input  logic              Busy,
`ifdef REGFILE_BYPASS_EN
  input  logic              WriteAccept,
  input  logic [ADDR_W-1:0] WriteSelect,
  input  logic [DATA_W-1:0] WriteData,
`endif
  output logic [DATA_W-1:0] ReadData
);
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    ReadData = (Busy || (ZERO_REG != 0 && Select == '0)) ? '0 :
               (WriteAccept && Select == WriteSelect) ? WriteData : Regs[Select];
`else
    ReadData = (Busy || (ZERO_REG != 0 && Select == '0)) ? '0 : Regs[Select];
`endif
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file with sequenced clear engine
// Optional REGFILE_BYPASS_EN forwards an accepted write to matching read ports in the same cycle.
module reg_file_mp import reg_file_pkg::*; #(
  parameter int DATA_W = DefDataW,
  parameter int ADDR_W = DefAddrW,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 0
) (
  input logic Clock,
  input logic Clear_n,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [NUM_READ*DATA_W-1:0] readData;
  logic [ADDR_W-1:0] ptr;
  logic writeAccept;
  regState_t state, nextState;
  always_ff @(posedge Clock) begin
    if (!Clear_n) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = (state == IDLE && bus.ClearReq) ? SWEEP :
                (state == SWEEP) ? (ptr == ADDR_W'(DEPTH-1) ? DONE : SWEEP) : IDLE;
  end
  always_comb begin
    bus.Busy = state == SWEEP;
    bus.ClearDone = state == DONE;
    bus.WriteReady = state != SWEEP;
    writeAccept = bus.WriteEnable && bus.WriteReady;
  end
  // A write and ClearReq in the same IDLE cycle both land; the sweep then zeroes the written entry.
  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      regs <= '{default: '0};
      ptr <= '0;
    end else begin
      if (writeAccept && !(ZERO_REG != 0 && bus.WriteSelect == '0)) regs[bus.WriteSelect] <= bus.WriteData;
      if (state == SWEEP) begin
        regs[ptr] <= '0;
        ptr <= ptr + 1'b1;
      end else if (state == IDLE && bus.ClearReq) ptr <= '0;
    end
  end
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) uPort (
      .Select(bus.ReadSelect[p*ADDR_W +: ADDR_W]),
      .Regs(regs),
      .Busy(bus.Busy),
`ifdef REGFILE_BYPASS_EN
      .WriteAccept(writeAccept),
      .WriteSelect(bus.WriteSelect),
      .WriteData(bus.WriteData),
`endif
      .ReadData(readData[p*DATA_W +: DATA_W])
    );
  end
  assign bus.ReadData = readData;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed plus random checks of reg_file_mp (ZERO_REG=0 and =1) against a behavioural model
module tb_reg_file_mp;
  logic Clock = 0;
  logic Clear_n = 0;
  logic we = 0, cr = 0;
  logic [3:0] ws = 0, rs0 = 0, rs1 = 0;
  logic [17:0] wd = 0;
  int checks = 0, failures = 0;
  int busySeen = 0, doneSeen = 0;
  logic [17:0] mem [16];
  int sweepLeft = 0;
  bit done = 0;

  always #5 Clock = ~Clock;

  reg_file_mp_if #(.DATA_W(18), .ADDR_W(4), .NUM_READ(2)) bus0 ();
  reg_file_mp_if #(.DATA_W(18), .ADDR_W(4), .NUM_READ(2)) bus1 ();
  assign bus0.ReadSelect = {rs1, rs0};
  assign bus0.WriteSelect = ws;
  assign bus0.WriteData = wd;
  assign bus0.WriteEnable = we;
  assign bus0.ClearReq = cr;
  assign bus1.ReadSelect = {rs1, rs0};
  assign bus1.WriteSelect = ws;
  assign bus1.WriteData = wd;
  assign bus1.WriteEnable = we;
  assign bus1.ClearReq = cr;

  reg_file_mp #(.DATA_W(18), .ADDR_W(4), .NUM_READ(2), .ZERO_REG(0)) dut0 (.Clock(Clock), .Clear_n(Clear_n), .bus(bus0));
  reg_file_mp #(.DATA_W(18), .ADDR_W(4), .NUM_READ(2), .ZERO_REG(1)) dut1 (.Clock(Clock), .Clear_n(Clear_n), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] expRd(input bit zr, input logic [3:0] sel);
    if (sweepLeft > 0) return '0;
    if (zr && sel == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && sel == ws) return wd;
`endif
    return mem[sel];
  endfunction

  // Check outputs mid-cycle, then advance one clock and update the model.
  task automatic cycle();
    @(negedge Clock);
    chk("rd0_p0", {14'd0, bus0.ReadData[17:0]}, {14'd0, expRd(0, rs0)});
    chk("rd0_p1", {14'd0, bus0.ReadData[35:18]}, {14'd0, expRd(0, rs1)});
    chk("rd1_p0", {14'd0, bus1.ReadData[17:0]}, {14'd0, expRd(1, rs0)});
    chk("rd1_p1", {14'd0, bus1.ReadData[35:18]}, {14'd0, expRd(1, rs1)});
    chk("busy", {31'd0, bus0.Busy}, {31'd0, sweepLeft > 0});
    chk("ready", {31'd0, bus0.WriteReady}, {31'd0, sweepLeft == 0});
    chk("done", {31'd0, bus0.ClearDone}, {31'd0, done});
    chk("busy1", {31'd0, bus1.Busy}, {31'd0, sweepLeft > 0});
    chk("done1", {31'd0, bus1.ClearDone}, {31'd0, done});
    busySeen += int'(bus0.Busy);
    doneSeen += int'(bus0.ClearDone);
    @(posedge Clock);
    if (!Clear_n) begin
      foreach (mem[i]) mem[i] = '0;
      sweepLeft = 0;
      done = 0;
    end else begin
      bit nd = sweepLeft == 1;
      if (we && sweepLeft == 0) mem[ws] = wd;
      if (sweepLeft > 0) begin
        sweepLeft--;
        if (sweepLeft == 0) foreach (mem[i]) mem[i] = '0;
      end else if (cr && !done) sweepLeft = 16;
      done = nd;
    end
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] a, input logic [17:0] d, input logic c,
                       input logic [3:0] r0, input logic [3:0] r1);
    we = w; ws = a; wd = d; cr = c; rs0 = r0; rs1 = r1;
    cycle();
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    @(posedge Clock);
    #1;
    drive(0, 0, 0, 0, 0, 1);
    Clear_n = 1;
    for (int i = 0; i < 16; i++) drive(1, 4'(i), 18'h3FFFF, 0, 4'(i), 4'(i + 1));
    Clear_n = 0;
    drive(0, 0, 0, 0, 2, 3);
    Clear_n = 1;
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 4'(i), 4'(i + 8));
    drive(1, 5, 18'h1234, 0, 5, 6);
    drive(0, 0, 0, 0, 5, 5);
    drive(0, 0, 0, 0, 6, 5);
    drive(1, 0, 18'h00FF, 0, 1, 2);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(1, 4'(i), 18'($urandom), 0, 4'(i), 4'(15 - i));
    busySeen = 0;
    doneSeen = 0;
    drive(0, 0, 0, 1, 3, 9);
    for (int i = 0; i < 20; i++) drive(1, 4'($urandom), 18'($urandom), 0, 4'($urandom), 4'($urandom));
    chk("sweep_len", busySeen, 16);
    chk("done_pulses", doneSeen, 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 4'(i), 4'(i + 8));
    drive(1, 3, 18'h11111, 0, 3, 4);
    drive(1, 3, 18'h2AAAA, 0, 3, 3);
    drive(0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 16; i++) drive(1, 4'(i), 18'($urandom), 0, 4'(i), 4'(i));
    busySeen = 0;
    doneSeen = 0;
    drive(0, 0, 0, 1, 1, 2);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 4'(i), 4'(i + 1));
    Clear_n = 0;
    drive(0, 0, 0, 0, 7, 8);
    Clear_n = 1;
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 4'(i), 4'(i + 4));
    chk("abort_busy", busySeen, 8);
    chk("abort_done", doneSeen, 0);
    for (int i = 0; i < 400; i++) begin
      Clear_n = ($urandom_range(0, 149) != 0);
      drive(1'($urandom), 4'($urandom), 18'($urandom), $urandom_range(0, 39) == 0, 4'($urandom), 4'($urandom));
    end
    Clear_n = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
